// File: rtl/piso_serializer.sv
// rtl/piso_serializer.sv - parallel-in serial-out loader with valid/ready input and framed serial output
module piso_serializer #(
    parameter int   WIDTH        = 8,
    parameter int   CLKS_PER_BIT = 1,
    parameter logic MSB_FIRST    = 1'b1,
    parameter logic IDLE_LEVEL   = 1'b0
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [WIDTH-1:0] DIN,
    input  logic             DIN_VALID,
    output logic             DIN_READY,
    output logic             SOUT,
    output logic             SOUT_VALID,
    output logic             FRAME_DONE,
    output logic             BUSY
);

    localparam int BW = $clog2(WIDTH + 1);
    localparam int DW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);
    localparam logic [DW-1:0] DIV_LAST = DW'(CLKS_PER_BIT - 1);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    state_t            state_q;
    logic [WIDTH-1:0]  shadow_q;
    logic [WIDTH-1:0]  shadow_d;
    logic [BW-1:0]     bit_cnt_q;
    logic [DW-1:0]     div_cnt_q;
    logic              sout_q;
    logic              sout_valid_q;
    logic              frame_done_q;
    logic              busy_q;
    logic              din_first;
    logic              next_bit;
    logic              accept;

    // Shadow register moves one position towards the output end; the bit now at
    // that end is the one driven next. DIN is only looked at for the first bit.
    always_comb begin
        shadow_d  = MSB_FIRST ? {shadow_q[WIDTH-2:0], 1'b0} : {1'b0, shadow_q[WIDTH-1:1]};
        next_bit  = MSB_FIRST ? shadow_d[WIDTH-1] : shadow_d[0];
        din_first = MSB_FIRST ? DIN[WIDTH-1] : DIN[0];
        accept    = DIN_VALID && DIN_READY;
    end

    assign DIN_READY  = (state_q == ST_IDLE) && !RST;
    assign SOUT       = sout_q;
    assign SOUT_VALID = sout_valid_q;
    assign FRAME_DONE = frame_done_q;
    assign BUSY       = busy_q;

    // Frame FSM: loads the shadow on accept, holds each bit for CLKS_PER_BIT
    // cycles, then drops back to idle with a single-cycle FRAME_DONE.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q      <= ST_IDLE;
            shadow_q     <= '0;
            bit_cnt_q    <= '0;
            div_cnt_q    <= '0;
            sout_q       <= IDLE_LEVEL;
            sout_valid_q <= 1'b0;
            frame_done_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    frame_done_q <= 1'b0;
                    bit_cnt_q    <= '0;
                    div_cnt_q    <= '0;
                    if (accept) begin
                        state_q      <= ST_SHIFT;
                        shadow_q     <= DIN;
                        sout_q       <= din_first;
                        sout_valid_q <= 1'b1;
                        busy_q       <= 1'b1;
                    end else begin
                        sout_q       <= IDLE_LEVEL;
                        sout_valid_q <= 1'b0;
                        busy_q       <= 1'b0;
                    end
                end
                ST_SHIFT: begin
                    if (div_cnt_q == DIV_LAST) begin
                        div_cnt_q <= '0;
                        if (bit_cnt_q == BIT_LAST) begin
                            // Last bit has been held its full time: close the frame.
                            state_q      <= ST_IDLE;
                            bit_cnt_q    <= '0;
                            sout_q       <= IDLE_LEVEL;
                            sout_valid_q <= 1'b0;
                            busy_q       <= 1'b0;
                            frame_done_q <= 1'b1;
                        end else begin
                            shadow_q  <= shadow_d;
                            sout_q    <= next_bit;
                            bit_cnt_q <= bit_cnt_q + 1'b1;
                        end
                    end else begin
                        div_cnt_q <= div_cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_piso_serializer.sv
// tb/tb_piso_serializer.sv - directed self-checking bench for piso_serializer
module tb_piso_serializer;

    logic       clk = 1'b0;
    logic [7:0] din [3];
    logic       dv  [3];
    logic       rst [3];
    logic       rdy [3];
    logic       so  [3];
    logic       sv  [3];
    logic       fd  [3];
    logic       bz  [3];
    logic       c1, c2, c3;
    int         n_checks = 0;
    int         n_errors = 0;

    always #5 clk = ~clk;

    // u0: MSB first, 1 cycle/bit; u1: LSB first, 1 cycle/bit; u2: MSB first, 3 cycles/bit
    piso_serializer #(.WIDTH(8), .CLKS_PER_BIT(1), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) u0 (
        .CLK(clk), .RST(rst[0]), .DIN(din[0]), .DIN_VALID(dv[0]), .DIN_READY(rdy[0]),
        .SOUT(so[0]), .SOUT_VALID(sv[0]), .FRAME_DONE(fd[0]), .BUSY(bz[0]));
    piso_serializer #(.WIDTH(8), .CLKS_PER_BIT(1), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b0)) u1 (
        .CLK(clk), .RST(rst[1]), .DIN(din[1]), .DIN_VALID(dv[1]), .DIN_READY(rdy[1]),
        .SOUT(so[1]), .SOUT_VALID(sv[1]), .FRAME_DONE(fd[1]), .BUSY(bz[1]));
    piso_serializer #(.WIDTH(8), .CLKS_PER_BIT(3), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) u2 (
        .CLK(clk), .RST(rst[2]), .DIN(din[2]), .DIN_VALID(dv[2]), .DIN_READY(rdy[2]),
        .SOUT(so[2]), .SOUT_VALID(sv[2]), .FRAME_DONE(fd[2]), .BUSY(bz[2]));

    // Downstream 3-stage shift chain fed from u0
    always_ff @(posedge clk) begin
        if (rst[0]) begin
            c1 <= 1'b0;
            c2 <= 1'b0;
            c3 <= 1'b0;
        end else begin
            c1 <= so[0];
            c2 <= c1;
            c3 <= c2;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // seq lists the expected SOUT bits in transmit order, seq[7] first.
    task automatic frame(input int d, input logic [7:0] word, input logic [7:0] seq, input int cpb);
        @(negedge clk);
        check("ready_pre", 32'(rdy[d]), 1);
        din[d] = word;
        dv[d]  = 1'b1;
        @(posedge clk);
        #1;
        dv[d]  = 1'b0;
        din[d] = ~word;
        for (int c = 1; c <= 8 * cpb; c++) begin
            @(negedge clk);
            check("sout", 32'(so[d]), 32'(seq[7 - (c - 1) / cpb]));
            check("valid", 32'(sv[d]), 1);
            check("busy", 32'(bz[d]), 1);
            check("done_low", 32'(fd[d]), 0);
        end
        @(negedge clk);
        check("done", 32'(fd[d]), 1);
        check("valid_off", 32'(sv[d]), 0);
        check("sout_idle", 32'(so[d]), 0);
        check("ready_done", 32'(rdy[d]), 1);
        check("busy_off", 32'(bz[d]), 0);
        @(negedge clk);
        check("done_pulse", 32'(fd[d]), 0);
    endtask

    initial begin
        logic [7:0] s0;
        logic [7:0] s1;
        int         j;
        for (int i = 0; i < 3; i++) begin
            din[i] = 8'h00;
            dv[i]  = 1'b0;
            rst[i] = 1'b1;
        end
        repeat (3) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            check("rst_sout", 32'(so[i]), 0);
            check("rst_valid", 32'(sv[i]), 0);
            check("rst_done", 32'(fd[i]), 0);
            check("rst_busy", 32'(bz[i]), 0);
            check("rst_ready", 32'(rdy[i]), 0);
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) rst[i] = 1'b0;

        // 1: A5 MSB first -> 1,0,1,0,0,1,0,1
        frame(0, 8'hA5, 8'hA5, 1);
        // 2: 01 LSB first -> 1 then seven 0s
        frame(1, 8'h01, 8'h80, 1);
        // 3: 80 MSB first, 3 cycles per bit
        frame(2, 8'h80, 8'h80, 3);

        // 4: back-to-back with DIN_VALID held and DIN swapped mid-frame
        s0 = 8'h3C;
        s1 = 8'hC3;
        @(negedge clk);
        din[0] = 8'h3C;
        dv[0]  = 1'b1;
        @(posedge clk);
        #1;
        din[0] = 8'hC3;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            check("b2b_sout0", 32'(so[0]), 32'(s0[8 - c]));
            check("b2b_ready_busy", 32'(rdy[0]), 0);
        end
        @(negedge clk);
        check("b2b_done", 32'(fd[0]), 1);
        check("b2b_ready", 32'(rdy[0]), 1);
        check("b2b_gap_valid", 32'(sv[0]), 0);
        check("b2b_gap_sout", 32'(so[0]), 0);
        @(posedge clk);
        #1;
        dv[0]  = 1'b0;
        din[0] = 8'h00;
        for (int c = 10; c <= 17; c++) begin
            @(negedge clk);
            check("b2b_sout1", 32'(so[0]), 32'(s1[17 - c]));
            check("b2b_valid1", 32'(sv[0]), 1);
        end
        @(negedge clk);
        check("b2b_done1", 32'(fd[0]), 1);

        // 5: reset in cycle 4 of an FF frame, then reset coincident with a request
        @(negedge clk);
        din[0] = 8'hFF;
        dv[0]  = 1'b1;
        @(posedge clk);
        #1;
        dv[0] = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            check("abort_sout", 32'(so[0]), 1);
        end
        @(posedge clk);
        #1;
        rst[0] = 1'b1;
        @(negedge clk);
        check("abort_c4_sout", 32'(so[0]), 1);
        check("abort_c4_ready", 32'(rdy[0]), 0);
        @(negedge clk);
        check("abort_sout0", 32'(so[0]), 0);
        check("abort_valid", 32'(sv[0]), 0);
        check("abort_busy", 32'(bz[0]), 0);
        check("abort_done", 32'(fd[0]), 0);
        check("abort_ready", 32'(rdy[0]), 0);
        din[0] = 8'h0F;
        dv[0]  = 1'b1;
        @(posedge clk);
        #1;
        rst[0] = 1'b0;
        dv[0]  = 1'b0;
        @(negedge clk);
        check("rst_accept_busy", 32'(bz[0]), 0);
        check("rst_accept_valid", 32'(sv[0]), 0);
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            check("abort_no_done", 32'(fd[0]), 0);
        end
        frame(0, 8'hFF, 8'hFF, 1);

        // 6: 3-stage chain output equals SOUT delayed by 3 cycles
        s0 = 8'hA5;
        @(negedge clk);
        din[0] = 8'hA5;
        dv[0]  = 1'b1;
        @(posedge clk);
        #1;
        dv[0] = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            j = k - 3;
            check("chain", 32'(c3), (j >= 1 && j <= 8) ? 32'(s0[8 - j]) : 32'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
